// File: rtl/pc_fetch_seq_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_seq_if
//   Instruction-memory fetch handshake between the PC sequencer and memory.
//
//   Signals:
//     imem_req   fetch request (driven by the sequencer)
//     imem_addr  fetch address (driven by the sequencer)
//     imem_ack   memory completes the outstanding request this cycle
//
//   Modports:
//     master  - the fetch sequencer (drives req/addr, receives ack)
//     slave   - the instruction memory (receives req/addr, drives ack)
// -----------------------------------------------------------------------------
interface pc_fetch_seq_if #(
    parameter int WIDTH = 12
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_seq.sv
// -----------------------------------------------------------------------------
// pc_fetch_seq
//   Program-counter register and instruction-fetch sequencer. Consumes the
//   next-PC mux output (pc_next) and feeds pc_plus4 back to the mux's
//   sequential input. Runs a req/ack handshake with instruction memory and
//   supports stall and squashing of a fetch that was overtaken by a redirect.
//
//   Parameters:
//     WIDTH     PC / address width
//     RESET_PC  PC value loaded on reset
//     STEP      sequential increment used for pc_plus4
//
//   Ports:
//     clk, reset_n   clock; asynchronous active-low reset
//     pc_next        selected next PC from the next-PC mux
//     redirect       pc_next is a non-sequential target this cycle
//     stall          hold off issuing the next fetch request
//     imem           fetch handshake (master side): imem_req/imem_addr/imem_ack
//     fetch_valid    one-cycle pulse: instruction at fetch_pc is valid
//     fetch_pc       address of the instruction flagged by fetch_valid
//     pc             current PC (outstanding or next fetch address)
//     pc_plus4       pc + STEP (wraps), combinational
//     misalign       (PC_ALIGN_CHECK_EN only) pulses one cycle after a
//                    misaligned value was loaded (and forced aligned) into pc
//
//   Configuration macro: PC_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module pc_fetch_seq #(
    parameter int WIDTH    = 12,
    parameter int RESET_PC = 0,
    parameter int STEP     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   pc_next,
    input  logic               redirect,
    input  logic               stall,
    pc_fetch_seq_if.master     imem,
    output logic               fetch_valid,
    output logic [WIDTH-1:0]   fetch_pc,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pc_plus4
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic               misalign
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic             req_q;
    logic             pend;      // a redirect arrived while a fetch was outstanding
    logic [WIDTH-1:0] pend_pc;   // newest such redirect target
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] load_fix;

    // Carry out of the top bit is simply dropped: the PC wraps.
    assign pc_plus4       = pc + WIDTH'(STEP);
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req_q;

    // Decide whether pc is loaded this cycle and with what.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        load_en  = 1'b0;
        load_val = pc_next;
        unique case (state)
            REQ: begin
                if (imem.imem_ack) begin
                    load_en = 1'b1;
                    // A stored redirect replaces the sequential target, but a
                    // redirect arriving in the ack cycle itself is newer still.
                    if (pend && !redirect) begin
                        load_val = pend_pc;
                    end
                end
            end
            // Nothing outstanding in HOLD, so a redirect takes effect at once.
            HOLD:    load_en = redirect;
            default: load_en = 1'b0;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic load_bad;
    assign load_fix = {load_val[WIDTH-1:2], 2'b00};
    assign load_bad = load_en && (load_val[1:0] != 2'b00);
`else
    assign load_fix = load_val;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            req_q       <= 1'b0;
            pc          <= WIDTH'(RESET_PC);
            fetch_pc    <= WIDTH'(RESET_PC);
            fetch_valid <= 1'b0;
            pend        <= 1'b0;
            pend_pc     <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign    <= 1'b0;
`endif
        end else begin
            fetch_valid <= 1'b0;
            if (load_en) begin
                pc <= load_fix;
            end
`ifdef PC_ALIGN_CHECK_EN
            misalign <= load_bad;
`endif
            unique case (state)
                BOOT: begin
                    // First fetch is issued regardless of stall.
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        // A fetch overtaken by a redirect is squashed silently.
                        if (!pend) begin
                            fetch_valid <= 1'b1;
                            fetch_pc    <= pc;
                        end
                        pend <= 1'b0;
                        if (stall) begin
                            state <= HOLD;
                            req_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        pend    <= 1'b1;
                        pend_pc <= pc_next;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_seq
//   Self-checking bench for pc_fetch_seq. A cycle model predicts req/addr/pc
//   each cycle; expected fetch addresses are queued when an ack is driven and
//   compared when the DUT raises fetch_valid.
//   Honours PC_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pc_fetch_seq;

    localparam int W      = 12;
    localparam int S_BOOT = 0;
    localparam int S_REQ  = 1;
    localparam int S_HOLD = 2;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] pc_next;
    logic         redirect;
    logic         stall;
    logic         fetch_valid;
    logic [W-1:0] fetch_pc;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign;
`endif

    pc_fetch_seq_if #(.WIDTH(W)) imem_bus ();

    pc_fetch_seq #(.WIDTH(W), .RESET_PC(0), .STEP(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .stall       (stall),
        .imem        (imem_bus),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int           m_state;
    logic [W-1:0] m_pc;
    logic         m_pend;
    logic [W-1:0] m_pend_pc;
    logic         m_fv;
    logic         m_mis;
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = S_BOOT;
        m_pc      = '0;
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_fv      = 1'b0;
        m_mis     = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic         ld;
        logic [W-1:0] lv;
        ld    = 1'b0;
        lv    = pc_next;
        m_fv  = 1'b0;
        case (m_state)
            S_BOOT: m_state = S_REQ;
            S_REQ: begin
                if (imem_bus.imem_ack) begin
                    if (m_pend) begin
                        lv = redirect ? pc_next : m_pend_pc;
                    end else begin
                        m_fv = 1'b1;
                        exp_q.push_back(m_pc);
                    end
                    ld     = 1'b1;
                    m_pend = 1'b0;
                    if (stall) m_state = S_HOLD;
                end else if (redirect) begin
                    m_pend    = 1'b1;
                    m_pend_pc = pc_next;
                end
            end
            default: begin
                if (redirect) ld = 1'b1;
                if (!stall) m_state = S_REQ;
            end
        endcase
        m_mis = 1'b0;
        if (ld) begin
`ifdef PC_ALIGN_CHECK_EN
            m_mis = (lv[1:0] != 2'b00);
            lv[1:0] = 2'b00;
`endif
            m_pc = lv;
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] e;
        check("imem_req", imem_bus.imem_req, m_state == S_REQ);
        check("imem_addr", imem_bus.imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, W'(m_pc + 12'd4));
        check("fetch_valid", fetch_valid, m_fv);
        if (fetch_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fetch_pc", fetch_pc, e);
        end
`ifdef PC_ALIGN_CHECK_EN
        check("misalign", misalign, m_mis);
`endif
    endtask

    // One clock: drive inputs, step the model, sample 1 time unit after the edge.
    task automatic cyc(input logic rd, input logic st, input logic ak,
                       input logic use_seq, input logic [W-1:0] tgt);
        redirect          = rd;
        stall             = st;
        imem_bus.imem_ack = ak;
        pc_next           = use_seq ? W'(m_pc + 12'd4) : tgt;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_req", imem_bus.imem_req, 1'b0);
        check("rst_async_pc", pc, 12'h000);
        check("rst_fetch_valid", fetch_valid, 1'b0);
        check("rst_fetch_pc", fetch_pc, 12'h000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n           = 1'b1;
        redirect          = 1'b0;
        stall             = 1'b0;
        pc_next           = '0;
        imem_bus.imem_ack = 1'b0;
        model_reset();
        apply_reset();

        // 1. Sequential fetch, ack tied high: one fetch per cycle.
        cyc(0, 0, 1, 1, '0);
        check("t1_addr0", imem_bus.imem_addr, 12'h000);
        cyc(0, 0, 1, 1, '0);
        check("t1_addr1", imem_bus.imem_addr, 12'h004);
        cyc(0, 0, 1, 1, '0);
        check("t1_addr2", imem_bus.imem_addr, 12'h008);
        check("t1_valid", fetch_valid, 1'b1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, '0);

        // 2. Wrap at the top of the address space.
        cyc(0, 0, 1, 0, 12'hFFC);
        check("t2_plus4_wrap", pc_plus4, 12'h000);
        cyc(0, 0, 1, 1, '0);
        check("t2_addr_wrap", imem_bus.imem_addr, 12'h000);

        // 3. Redirect during a wait squashes the outstanding fetch.
        cyc(0, 0, 1, 0, 12'h010);
        cyc(1, 0, 0, 0, 12'h200);
        check("t3_wait_addr", imem_bus.imem_addr, 12'h010);
        cyc(0, 0, 0, 0, 12'h014);
        cyc(0, 0, 0, 0, 12'h014);
        check("t3_wait_addr2", imem_bus.imem_addr, 12'h010);
        cyc(0, 0, 1, 0, 12'h014);
        check("t3_squash", fetch_valid, 1'b0);
        check("t3_new_addr", imem_bus.imem_addr, 12'h200);
        //    Last of several redirects wins.
        cyc(1, 0, 0, 0, 12'h300);
        cyc(1, 0, 0, 0, 12'h340);
        cyc(0, 0, 1, 0, 12'h204);
        check("t3_last_wins", pc, 12'h340);
        //    Redirect in the ack cycle beats the stored one.
        cyc(1, 0, 0, 0, 12'h400);
        cyc(1, 0, 1, 0, 12'h480);
        check("t3_ack_redirect", pc, 12'h480);
        cyc(0, 0, 1, 1, '0);

        // 4. Stall into HOLD, redirect in HOLD, release.
        cyc(0, 0, 1, 0, 12'h020);
        cyc(0, 1, 1, 0, 12'h024);
        check("t4_hold_req", imem_bus.imem_req, 1'b0);
        check("t4_hold_pc", pc, 12'h024);
        cyc(0, 1, 1, 0, 12'h0AA);
        check("t4_pc_held", pc, 12'h024);
        cyc(0, 0, 0, 0, 12'h0BB);
        check("t4_resume_addr", imem_bus.imem_addr, 12'h024);
        check("t4_resume_req", imem_bus.imem_req, 1'b1);
        cyc(0, 1, 1, 1, '0);
        cyc(1, 1, 0, 0, 12'h500);
        check("t4_hold_redirect", pc, 12'h500);
        cyc(0, 0, 0, 0, 12'h000);
        cyc(0, 0, 1, 1, '0);

        // 5. Async reset during an outstanding request.
        cyc(0, 0, 1, 0, 12'h100);
        cyc(0, 0, 0, 0, 12'h000);
        check("t5_wait_pc", pc, 12'h100);
        apply_reset();
        cyc(0, 0, 1, 1, '0);
        check("t5_restart_addr", imem_bus.imem_addr, 12'h000);
        cyc(0, 0, 1, 1, '0);

        // 6. Misaligned target.
        cyc(0, 0, 1, 0, 12'h033);
`ifdef PC_ALIGN_CHECK_EN
        check("t6_aligned_pc", pc, 12'h030);
        check("t6_misalign", misalign, 1'b1);
        cyc(0, 0, 1, 1, '0);
        check("t6_misalign_drop", misalign, 1'b0);
`else
        check("t6_raw_pc", pc, 12'h033);
        cyc(0, 0, 1, 1, '0);
`endif
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, '0);
        cyc(0, 0, 0, 1, '0);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
